// File: rtl/cpu_memory_pkg.sv
// cpu_memory_pkg: loader state encodings and word constants shared by the
// memory block and the CPU core.
package cpu_memory_pkg;

  localparam int WORD_SIZE = 16;
  localparam logic [WORD_SIZE-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HI   = 3'd1,
    LD_LO   = 3'd2,
    LD_WR   = 3'd3,
    LD_FIN  = 3'd4
  } ld_state_t;

endpackage

// File: rtl/mem_loader.sv
// mem_loader: byte-stream program loader that assembles big-endian words and
// writes them from address 0; optional checksum under CPU_MEM_CHECKSUM_EN.
//
// state   | meaning
// LD_IDLE | CPU owns memory, waiting for ld_start
// LD_HI   | waiting for the high byte of the current word
// LD_LO   | waiting for the low byte of the current word
// LD_WR   | writing the assembled word, advancing address/count
// LD_FIN  | one-cycle done pulse, memory released on exit
module mem_loader
  import cpu_memory_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int WORD_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_start,
  input  logic [15:0]           ld_len,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  ld_err,
  output logic                  cpu_hold,
  output logic [WORD_SIZE-1:0]  ld_sum,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [WORD_SIZE-1:0]  wr_data
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [16:0] DEPTH_W = 17'(1) << DEPTH_LOG2;

  ld_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [7:0]            hi_q;
  logic [15:0]           word_q;
  logic                  err_q;
  logic                  len_zero, len_big, start_ok;

  assign len_zero = (ld_len == 16'h0000);
  assign len_big  = ({1'b0, ld_len} > DEPTH_W);
  assign start_ok = (state_q == LD_IDLE) && ld_start && !len_zero && !len_big;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      LD_IDLE: if (ld_start) state_d = (len_zero || len_big) ? LD_FIN : LD_HI;
      LD_HI: begin
        ld_ready = 1'b1;
        if (ld_valid) state_d = LD_LO;
      end
      LD_LO: begin
        ld_ready = 1'b1;
        if (ld_valid) state_d = LD_WR;
      end
      LD_WR: begin
        wr_en   = 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? LD_FIN : LD_HI;
      end
      LD_FIN: begin
        ld_done = 1'b1;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Count is sized for LD_LEN == depth, so ld_len fits after the range check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      hi_q   <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state_q == LD_IDLE) && ld_start && len_big) err_q <= 1'b1;
      if (start_ok) begin
        err_q  <= 1'b0;
        cnt_q  <= ld_len[CNT_W-1:0];
        addr_q <= '0;
      end
      if ((state_q == LD_HI) && ld_valid) hi_q <= ld_byte;
      if ((state_q == LD_LO) && ld_valid) word_q <= {hi_q, ld_byte};
      if (wr_en) begin
        addr_q <= addr_q + DEPTH_LOG2'(1);
        cnt_q  <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign ld_err   = err_q;
  assign cpu_hold = (state_q != LD_IDLE);
  assign wr_addr  = addr_q;
  assign wr_data  = WORD_SIZE'(word_q);

`ifdef CPU_MEM_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum_q <= '0;
    else if (start_ok) sum_q <= '0;
    else if (wr_en)    sum_q <= sum_q + wr_data;
  end

  assign ld_sum = sum_q;
`else
  assign ld_sum = '0;
`endif

endmodule

// File: rtl/cpu_memory.sv
// cpu_memory: unified word memory for the multi-cycle core with a built-in
// program loader (checksum output enabled by CPU_MEM_CHECKSUM_EN).
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int WORD_SIZE  = 16
) (
  input  logic                 DCLK,
  input  logic                 RSTn,
  input  logic                 M_W,
  input  logic [15:0]          MADDR,
  input  logic [WORD_SIZE-1:0] MDATAOUT,
  output logic [WORD_SIZE-1:0] MDATAIN,
  input  logic                 LD_START,
  input  logic [15:0]          LD_LEN,
  input  logic                 LD_VALID,
  input  logic [7:0]           LD_BYTE,
  output logic                 LD_READY,
  output logic                 LD_DONE,
  output logic                 LD_ERR,
  output logic                 CPU_HOLD,
  output logic [WORD_SIZE-1:0] LD_SUM
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_SIZE-1:0]  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] cpu_idx;
  logic                  ld_wr_en;
  logic [DEPTH_LOG2-1:0] ld_wr_addr;
  logic [WORD_SIZE-1:0]  ld_wr_data;
  logic                  unused_maddr;

  // Upper address bits are ignored so CPU addresses wrap modulo the depth.
  assign cpu_idx      = MADDR[DEPTH_LOG2-1:0];
  assign unused_maddr = ^MADDR[15:DEPTH_LOG2];

  mem_loader #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WORD_SIZE (WORD_SIZE)
  ) u_loader (
    .clk     (DCLK),
    .rst_n   (RSTn),
    .ld_start(LD_START),
    .ld_len  (LD_LEN),
    .ld_valid(LD_VALID),
    .ld_byte (LD_BYTE),
    .ld_ready(LD_READY),
    .ld_done (LD_DONE),
    .ld_err  (LD_ERR),
    .cpu_hold(CPU_HOLD),
    .ld_sum  (LD_SUM),
    .wr_en   (ld_wr_en),
    .wr_addr (ld_wr_addr),
    .wr_data (ld_wr_data)
  );

  // The array has no reset: a reset mid-load keeps words already written.
  always_ff @(posedge DCLK) begin
    if (ld_wr_en)              mem_q[ld_wr_addr] <= ld_wr_data;
    else if (M_W && !CPU_HOLD) mem_q[cpu_idx]    <= MDATAOUT;
  end

  assign MDATAIN = CPU_HOLD ? WORD_SIZE'(NOP_WORD) : mem_q[cpu_idx];

endmodule

// File: tb/tb_cpu_memory.sv
// tb_cpu_memory: directed and randomized checks of cpu_memory against a
// word-array reference model of CPU access and the program loader.
module tb_cpu_memory;

  localparam int DEPTH = 256;

  logic        DCLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        M_W = 1'b0;
  logic [15:0] MADDR = '0;
  logic [15:0] MDATAOUT = '0;
  logic [15:0] MDATAIN;
  logic        LD_START = 1'b0;
  logic [15:0] LD_LEN = '0;
  logic        LD_VALID = 1'b0;
  logic [7:0]  LD_BYTE = '0;
  logic        LD_READY, LD_DONE, LD_ERR, CPU_HOLD;
  logic [15:0] LD_SUM;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_sum = '0;
  logic [7:0]  stream [$];

  cpu_memory #(.DEPTH_LOG2(8), .WORD_SIZE(16)) dut (
    .DCLK(DCLK), .RSTn(RSTn), .M_W(M_W), .MADDR(MADDR), .MDATAOUT(MDATAOUT),
    .MDATAIN(MDATAIN), .LD_START(LD_START), .LD_LEN(LD_LEN), .LD_VALID(LD_VALID),
    .LD_BYTE(LD_BYTE), .LD_READY(LD_READY), .LD_DONE(LD_DONE), .LD_ERR(LD_ERR),
    .CPU_HOLD(CPU_HOLD), .LD_SUM(LD_SUM)
  );

  always #5 DCLK = ~DCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef CPU_MEM_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    M_W = 1'b1; MADDR = a; MDATAOUT = d;
    tick();
    M_W = 1'b0;
    model_mem[int'(a) % DEPTH] = d;
  endtask

  task automatic check_read(input string tag, input logic [15:0] a);
    MADDR = a;
    #1;
    check(tag, MDATAIN, model_mem[int'(a) % DEPTH]);
  endtask

  task automatic verify_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      MADDR = 16'(i + DEPTH * $urandom_range(0, 255));
      #1;
      check(tag, MDATAIN, model_mem[i]);
    end
    tick();
  endtask

  task automatic fill_stream(input int nbytes);
    stream.delete();
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom));
  endtask

  function automatic int next_gap(input int mode);
    if (mode == 1) return 3;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  // gap_mode: 0 = LD_VALID always offered, 1 = 3 idle cycles per byte, 2 = random 0..3
  task automatic do_load(input int len, input int gap_mode, input string tag);
    int   bi = 0;
    int   cyc = 0;
    int   done_cyc = -1;
    int   gap;
    bit   ok;
    bit   exp_err;
    int   nbytes;
    logic [15:0] sum = '0;
    ok      = (len > 0) && (len <= DEPTH);
    exp_err = (len > DEPTH) ? 1'b1 : (ok ? 1'b0 : LD_ERR);
    nbytes  = ok ? 2 * len : 0;
    LD_START = 1'b1; LD_LEN = 16'(len); LD_VALID = 1'b0;
    gap = next_gap(gap_mode);
    tick();
    LD_START = 1'b0; M_W = 1'b0;
    cyc = 1;
    check({tag, " err"}, LD_ERR, exp_err);
    while (done_cyc < 0 && cyc < 3000) begin
      if (LD_DONE) begin
        done_cyc = cyc;
      end else begin
        check({tag, " hold"}, CPU_HOLD, 1'b1);
        M_W = 1'($urandom_range(0, 1)); MADDR = 16'($urandom); MDATAOUT = 16'($urandom);
        #1;
        check({tag, " nop"}, MDATAIN, 16'h0000);
        if (bi < nbytes && gap == 0) begin
          LD_VALID = 1'b1; LD_BYTE = stream[bi];
        end else begin
          LD_VALID = 1'b0; LD_BYTE = 8'($urandom);
          if (gap > 0) gap--;
        end
        if (LD_VALID && LD_READY) begin
          bi++;
          gap = next_gap(gap_mode);
        end
        tick();
        cyc++;
      end
    end
    check({tag, " done seen"}, done_cyc >= 0, 1'b1);
    check({tag, " fin hold"}, CPU_HOLD, 1'b1);
    check({tag, " bytes"}, bi, nbytes);
    if (gap_mode == 0) check({tag, " done cycle"}, done_cyc, ok ? 3 * len + 1 : 1);
    if (ok) begin
      for (int i = 0; i < len; i++) begin
        model_mem[i] = {stream[2 * i], stream[2 * i + 1]};
        sum = sum + model_mem[i];
      end
      model_sum = sum;
    end
    M_W = 1'b0; LD_VALID = 1'b0;
    tick();
    check({tag, " done pulse"}, LD_DONE, 1'b0);
    check({tag, " release"}, CPU_HOLD, 1'b0);
    check({tag, " err sticky"}, LD_ERR, exp_err);
    if (ok) check({tag, " sum"}, LD_SUM, exp_sum(model_sum));
  endtask

  initial begin
    #2;
    check("rst ready", LD_READY, 1'b0);
    check("rst done", LD_DONE, 1'b0);
    check("rst err", LD_ERR, 1'b0);
    check("rst hold", CPU_HOLD, 1'b0);
    check("rst sum", LD_SUM, 16'h0000);
    tick(); tick();
    RSTn = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) cpu_write(16'(i), 16'($urandom));
    verify_all("init");

    cpu_write(16'h0005, 16'h1234);
    MADDR = 16'h0005; #1;
    check("cpu rd 5", MDATAIN, 16'h1234);
    MADDR = 16'h0105; #1;
    check("cpu rd wrap", MDATAIN, 16'h1234);
    tick();

    stream.delete();
    stream.push_back(8'h91); stream.push_back(8'h02);
    stream.push_back(8'hA0); stream.push_back(8'h03);
    do_load(2, 0, "tp load2");
    MADDR = 16'h0000; #1;
    check("tp mem0", MDATAIN, 16'h9102);
    MADDR = 16'h0001; #1;
    check("tp mem1", MDATAIN, 16'hA003);
    check("tp sum", LD_SUM, exp_sum(16'h3105));
    verify_all("tp after load");

    do_load(257, 0, "len257");
    verify_all("len257 mem");
    fill_stream(2);
    do_load(1, 0, "clear err");
    verify_all("clear err mem");

    do_load(0, 0, "len0");

    fill_stream(10);
    do_load(5, 1, "gap3");
    verify_all("gap3 mem");

    M_W = 1'b1; MADDR = 16'h0130; MDATAOUT = 16'hBEEF;
    fill_stream(2);
    do_load(1, 0, "simul");
    model_mem[16'h30] = 16'hBEEF;
    check_read("simul cpu wr", 16'h0030);
    check_read("simul ld wr", 16'h0000);
    tick();

    fill_stream(6);
    LD_START = 1'b1; LD_LEN = 16'd3;
    tick();
    LD_START = 1'b0; LD_VALID = 1'b1; LD_BYTE = stream[0];
    tick();
    LD_BYTE = stream[1];
    tick();
    LD_VALID = 1'b0;
    tick();
    LD_VALID = 1'b1; LD_BYTE = stream[2];
    tick();
    LD_VALID = 1'b0;
    check("midrst pre hold", CPU_HOLD, 1'b1);
    RSTn = 1'b0;
    #1;
    check("midrst hold", CPU_HOLD, 1'b0);
    check("midrst ready", LD_READY, 1'b0);
    check("midrst done", LD_DONE, 1'b0);
    check("midrst sum", LD_SUM, 16'h0000);
    tick();
    RSTn = 1'b1;
    model_mem[0] = {stream[0], stream[1]};
    check_read("midrst kept", 16'h0000);
    check_read("midrst partial", 16'h0001);
    tick();
    verify_all("midrst mem");

    for (int it = 0; it < 10; it++) begin
      int len;
      int n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) cpu_write(16'($urandom), 16'($urandom));
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = int'($urandom_range(257, 400));
        2:       len = DEPTH;
        default: len = int'($urandom_range(1, 24));
      endcase
      fill_stream(2 * len);
      do_load(len, int'($urandom_range(0, 2)), "rand load");
      verify_all("rand mem");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
